// File: rtl/morse_keyer_ctrl.sv
// morse_keyer_ctrl
//   Turns a debounced Morse key level into dot/dash strobes for a downstream
//   decoder, detects the inter-symbol gap, commits the decoder's code as a
//   symbol, and flags word boundaries after a long quiet period.
//
// Parameters
//   DASH_TICKS  minimum held ticks classified as a dash
//   GAP_TICKS   released ticks that end a symbol (>= 1)
//   WORD_TICKS  released ticks that end a word (> GAP_TICKS)
//
// Ports
//   Clock       rising-edge clock
//   Reset       synchronous, active-high reset
//   key_in      key level, 1 = pressed
//   tick        one-cycle timebase strobe
//   dec_code    current code from the decoder
//   dot, dash   one-cycle element strobes to the decoder
//   dec_reset   one-cycle decoder clear (asserted during COMMIT)
//   sym_out     last committed symbol code
//   sym_valid   one-cycle strobe: sym_out is a valid symbol (0..35)
//   sym_err     one-cycle strobe: committed sequence was invalid
//   word_space  one-cycle strobe marking a word boundary
module morse_keyer_ctrl #(
    parameter int unsigned DASH_TICKS = 3,
    parameter int unsigned GAP_TICKS  = 3,
    parameter int unsigned WORD_TICKS = 7
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       key_in,
    input  logic       tick,
    input  logic [5:0] dec_code,
    output logic       dot,
    output logic       dash,
    output logic       dec_reset,
    output logic [5:0] sym_out,
    output logic       sym_valid,
    output logic       sym_err,
    output logic       word_space
);

    localparam int unsigned PW = $clog2(DASH_TICKS + 1);
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam int unsigned WW = $clog2(WORD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, COMMIT} state_t;

    state_t        state;
    logic [PW-1:0] pcnt;
    logic [GW-1:0] gcnt;
    logic [WW-1:0] wcnt;
    logic [2:0]    ecnt;
    logic          ovf;
    logic          armed;

    logic wcnt_inc;
    logic ws_hit;

    // Word counter advances on any released tick; in PRESS a released key is
    // the release cycle itself, whose tick belongs to the GAP that follows.
    // A commit in progress counts as armed so a same-cycle boundary is not lost.
    always_comb begin
        wcnt_inc = !key_in && tick && (wcnt != WW'(WORD_TICKS));
        ws_hit   = wcnt_inc && (wcnt == WW'(WORD_TICKS - 1))
                   && (armed || state == COMMIT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            pcnt       <= '0;
            gcnt       <= '0;
            wcnt       <= '0;
            ecnt       <= '0;
            ovf        <= 1'b0;
            armed      <= 1'b0;
            dot        <= 1'b0;
            dash       <= 1'b0;
            dec_reset  <= 1'b0;
            sym_out    <= '0;
            sym_valid  <= 1'b0;
            sym_err    <= 1'b0;
            word_space <= 1'b0;
        end else begin
            dot        <= 1'b0;
            dash       <= 1'b0;
            dec_reset  <= 1'b0;
            sym_valid  <= 1'b0;
            sym_err    <= 1'b0;
            word_space <= ws_hit;

            if (wcnt_inc)
                wcnt <= wcnt + WW'(1);

            case (state)
                IDLE: begin
                    if (key_in) begin
                        state <= PRESS;
                        pcnt  <= '0;
                        wcnt  <= '0;
                    end
                end
                PRESS: begin
                    if (key_in) begin
                        if (tick && pcnt != PW'(DASH_TICKS))
                            pcnt <= pcnt + PW'(1);
                    end else if (pcnt == '0) begin
                        // Glitch: no element, resume where the symbol was
                        state <= (ecnt == 3'd0) ? IDLE : GAP;
                        gcnt  <= '0;
                    end else begin
                        state <= GAP;
                        gcnt  <= '0;
                        if (ecnt == 3'd5) begin
                            ovf <= 1'b1;
                        end else begin
                            ecnt <= ecnt + 3'd1;
                            if (pcnt == PW'(DASH_TICKS))
                                dash <= 1'b1;
                            else
                                dot <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (key_in) begin
                        state <= PRESS;
                        pcnt  <= '0;
                        wcnt  <= '0;
                    end else if (tick) begin
                        if (gcnt == GW'(GAP_TICKS - 1)) begin
                            state     <= COMMIT;
                            dec_reset <= 1'b1;
                        end else begin
                            gcnt <= gcnt + GW'(1);
                        end
                    end
                end
                COMMIT: begin
                    sym_out   <= dec_code;
                    sym_valid <= (dec_code <= 6'd35) && !ovf;
                    sym_err   <= !((dec_code <= 6'd35) && !ovf);
                    ecnt      <= '0;
                    ovf       <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (ws_hit)
                armed <= 1'b0;
            else if (state == COMMIT)
                armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Directed testbench for morse_keyer_ctrl (default parameters).
module tb_morse_keyer_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       key_in;
    logic       tick;
    logic [5:0] dec_code;
    logic       dot, dash, dec_reset, sym_valid, sym_err, word_space;
    logic [5:0] sym_out;

    morse_keyer_ctrl #(.DASH_TICKS(3), .GAP_TICKS(3), .WORD_TICKS(7)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .key_in     (key_in),
        .tick       (tick),
        .dec_code   (dec_code),
        .dot        (dot),
        .dash       (dash),
        .dec_reset  (dec_reset),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .sym_err    (sym_err),
        .word_space (word_space)
    );

    always #5 Clock = ~Clock;

    int nerr = 0;
    int nchk = 0;
    int n_dot, n_dash, n_dr, n_sv, n_se, n_ws, n_both;
    int qt, dr_at, ws_at, nseq;
    int last_sym;
    logic [7:0] seqb;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_dot = 0; n_dash = 0; n_dr = 0; n_sv = 0; n_se = 0; n_ws = 0;
        dr_at = -1; ws_at = -1; nseq = 0; seqb = '0; last_sym = -1;
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later.
    task automatic step(input logic k, input logic t);
        key_in = k;
        tick   = t;
        if (k) qt = 0;
        else if (t) qt++;
        @(posedge Clock);
        #1;
        if (dot)  begin n_dot++;  seqb = {seqb[6:0], 1'b0}; nseq++; end
        if (dash) begin n_dash++; seqb = {seqb[6:0], 1'b1}; nseq++; end
        if (dot && dash) n_both++;
        if (dec_reset)  begin n_dr++; dr_at = qt; end
        if (sym_valid)  begin n_sv++; last_sym = int'(sym_out); end
        if (sym_err)    begin n_se++; last_sym = int'(sym_out); end
        if (word_space) begin n_ws++; ws_at = qt; end
    endtask

    task automatic press(input int nt);
        step(1'b1, 1'b0);
        repeat (nt) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
    endtask

    initial begin
        n_both = 0;
        qt = 0;
        clr();
        Reset = 1'b1; key_in = 1'b0; tick = 1'b0; dec_code = 6'd0;

        // Reset state
        step(1'b0, 1'b0);
        chk("reset_outputs",
            int'({dot, dash, dec_reset, sym_valid, sym_err, word_space, sym_out}), 0);
        Reset = 1'b0;
        clr();
        repeat (10) step(1'b0, 1'b1);
        chk("idle_no_strobes", n_dot + n_dash + n_dr + n_sv + n_se + n_ws, 0);

        // Letter E with full word gap
        dec_code = 6'd14;
        clr();
        press(1);
        quiet(12);
        chk("e_dot_count", n_dot, 1);
        chk("e_dash_count", n_dash, 0);
        chk("e_dec_reset_count", n_dr, 1);
        chk("e_dec_reset_tick", dr_at, 3);
        chk("e_sym_valid_count", n_sv, 1);
        chk("e_sym_err_count", n_se, 0);
        chk("e_sym_out", last_sym, 14);
        chk("e_word_space_count", n_ws, 1);
        chk("e_word_space_tick", ws_at, 7);
        chk("e_sym_out_hold", int'(sym_out), 14);

        // Letter C: dash dot dash dot
        dec_code = 6'd12;
        clr();
        press(4); quiet(1);
        press(1); quiet(1);
        press(4); quiet(1);
        press(1); quiet(10);
        chk("c_elements", nseq, 4);
        chk("c_order", int'(seqb[3:0]), 4'b1010);
        chk("c_sym_valid_count", n_sv, 1);
        chk("c_sym_out", last_sym, 12);
        chk("c_sym_err_count", n_se, 0);

        // Overflow: six dots, valid-looking code still rejected
        dec_code = 6'd5;
        clr();
        repeat (6) begin
            press(1);
            quiet(1);
        end
        quiet(10);
        chk("ovf_dot_count", n_dot, 5);
        chk("ovf_sym_err_count", n_se, 1);
        chk("ovf_sym_valid_count", n_sv, 0);

        // Incomplete code
        dec_code = 6'd37;
        clr();
        press(1);
        quiet(10);
        chk("inc_sym_err_count", n_se, 1);
        chk("inc_sym_valid_count", n_sv, 0);
        chk("inc_sym_out", last_sym, 37);

        // Glitch, then reset mid-press
        dec_code = 6'd14;
        clr();
        press(0);
        quiet(5);
        chk("glitch_strobes", n_dot + n_dash + n_dr, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        Reset = 1'b1;
        step(1'b1, 1'b0);
        Reset = 1'b0;
        quiet(6);
        chk("abort_strobes", n_dot + n_dash + n_dr + n_sv + n_se, 0);

        // Recovery after abort: a fresh dot commits normally
        clr();
        press(2);
        quiet(4);
        chk("recover_dot_count", n_dot, 1);
        chk("recover_sym_valid", n_sv, 1);

        chk("never_dot_and_dash", n_both, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
